// File: rtl/vga_tile_scanner_pkg.sv
// Raster constants for 640x480 @ 60 Hz, sync polarity, board geometry defaults
// and the small types shared by the scanner, its interface and the axis decoder.
package vga_timing_pkg;

   localparam int COORD_W = 10;
   typedef logic [COORD_W-1:0] coord_t;
   typedef logic [1:0]         tile_idx_t;

   localparam int H_VISIBLE = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

   localparam int V_VISIBLE = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;
   localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam coord_t H_SYNC_START = coord_t'(H_VISIBLE + H_FRONT);
   localparam coord_t H_SYNC_END   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam coord_t H_LAST       = coord_t'(H_TOTAL - 1);
   localparam coord_t V_SYNC_START = coord_t'(V_VISIBLE + V_FRONT);
   localparam coord_t V_SYNC_END   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);
   localparam coord_t V_LAST       = coord_t'(V_TOTAL - 1);

   // Both syncs are active-low on the connector
   localparam logic SYNC_ACTIVE = 1'b0;

   localparam int BOARD_X0_DEF   = 160;
   localparam int BOARD_Y0_DEF   = 80;
   localparam int TILE_PITCH_DEF = 80;
   localparam int TILE_SIZE_DEF  = 72;
   localparam int TILES_PER_AXIS = 4;

   function automatic logic sync_level(input logic active);
      return active ? SYNC_ACTIVE : ~SYNC_ACTIVE;
   endfunction

   function automatic logic in_range(input coord_t c, input coord_t lo, input coord_t hi);
      return (c >= lo) && (c <= hi);
   endfunction

endpackage

// File: rtl/vga_tile_scanner_if.sv
// Raster and tile-decode bundle from the scanner to the colour logic / VGA pins.
interface vga_tile_scanner_if;
   import vga_timing_pkg::*;

   logic      pix_en;
   coord_t    hCount;
   coord_t    vCount;
   logic      bright;
   logic      hSync;
   logic      vSync;
   logic      frame_start;
   logic      tile_hit;
   tile_idx_t tile_row;
   tile_idx_t tile_col;

   modport master (
      output pix_en, hCount, vCount, bright, hSync, vSync,
             frame_start, tile_hit, tile_row, tile_col
   );

   modport slave (
      input  pix_en, hCount, vCount, bright, hSync, vSync,
             frame_start, tile_hit, tile_row, tile_col
   );

endinterface

// File: rtl/vga_tile_scanner_tile_axis_decoder.sv
// One axis of the 4x4 board decode. Tracks position inside the board with a
// sub-counter and tile index; outputs describe the pixel entering on the next strobe.
module tile_axis_decoder
   import vga_timing_pkg::*;
#(
   parameter int C0    = BOARD_X0_DEF,
   parameter int PITCH = TILE_PITCH_DEF,
   parameter int SIZE  = TILE_SIZE_DEF
) (
   input  logic      clk,
   input  logic      rst,
   input  coord_t    i_coord_next,
   input  logic      i_advance,
   input  logic      i_wrap,
   output logic      o_in_board,
   output tile_idx_t o_index,
   output logic      o_inside
);

   localparam int SUB_W = $clog2(PITCH + 1);
   localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(PITCH - 1);
   localparam logic [SUB_W-1:0] SUB_SIZE = SUB_W'(SIZE);
   localparam tile_idx_t        IDX_LAST = tile_idx_t'(TILES_PER_AXIS - 1);
   localparam coord_t           COORD_0  = coord_t'(C0);

   logic             r_in;
   logic [SUB_W-1:0] r_sub;
   tile_idx_t        r_idx;

   logic             w_in_next;
   logic [SUB_W-1:0] w_sub_next;
   tile_idx_t        w_idx_next;

   // Next axis state: load at the board edge, step inside it, hold outside it
   always_comb begin
      w_in_next  = r_in;
      w_sub_next = r_sub;
      w_idx_next = r_idx;
      if (i_advance) begin
         if (i_coord_next == COORD_0) begin
            w_in_next  = 1'b1;
            w_sub_next = SUB_W'(0);
            w_idx_next = tile_idx_t'(0);
         end else if (i_wrap) begin
            w_in_next = 1'b0;
         end else if (r_in) begin
            if (r_sub == SUB_LAST) begin
               if (r_idx == IDX_LAST) begin
                  w_in_next = 1'b0;
               end else begin
                  w_sub_next = SUB_W'(0);
                  w_idx_next = r_idx + tile_idx_t'(1);
               end
            end else begin
               w_sub_next = r_sub + SUB_W'(1);
            end
         end else begin
            w_in_next = 1'b0;
         end
      end else begin
         w_in_next = r_in;
      end
      o_in_board = w_in_next;
      o_index    = w_idx_next;
      o_inside   = (w_sub_next < SUB_SIZE);
   end

   // Axis state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_in  <= 1'b0;
         r_sub <= SUB_W'(0);
         r_idx <= tile_idx_t'(0);
      end else begin
         r_in  <= w_in_next;
         r_sub <= w_sub_next;
         r_idx <= w_idx_next;
      end
   end

endmodule

// File: rtl/vga_tile_scanner.sv
// 640x480 @ 60 Hz raster generator with registered 4x4 board-tile decode; every
// output describes the pixel on hCount/vCount and changes the Clk after pix_en.
module vga_tile_scanner
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int BOARD_X0   = BOARD_X0_DEF,
   parameter int BOARD_Y0   = BOARD_Y0_DEF,
   parameter int TILE_PITCH = TILE_PITCH_DEF,
   parameter int TILE_SIZE  = TILE_SIZE_DEF
) (
   input  logic               Clk,
   input  logic               Reset,
   vga_tile_scanner_if.master vif
);

   localparam int PRE_W = $clog2(CLK_DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
   localparam logic [PRE_W-1:0] PRE_ARM  = PRE_W'(CLK_DIV - 2);

   logic [PRE_W-1:0] r_presc;
   logic             r_pix_en;
   coord_t           r_hcount;
   coord_t           r_vcount;
   logic             r_bright;
   logic             r_hsync;
   logic             r_vsync;
   logic             r_frame_start;
   logic             r_tile_hit;
   tile_idx_t        r_tile_row;
   tile_idx_t        r_tile_col;

   coord_t    w_h_next;
   coord_t    w_v_next;
   logic      w_h_wrap;
   logic      w_v_wrap;
   logic      w_line_adv;
   logic      w_bright_next;
   logic      w_hit_next;
   logic      w_x_in;
   logic      w_x_inside;
   logic      w_y_in;
   logic      w_y_inside;
   tile_idx_t w_x_idx;
   tile_idx_t w_y_idx;

   // Pixel prescaler; pix_en is armed one cycle early so it is high while the count is CLK_DIV-1
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_presc  <= PRE_W'(0);
         r_pix_en <= 1'b0;
      end else begin
         r_presc  <= (r_presc == PRE_LAST) ? PRE_W'(0) : r_presc + PRE_W'(1);
         r_pix_en <= (r_presc == PRE_ARM);
      end
   end

   // Raster position that becomes visible on the next edge, plus its look-ahead decode
   always_comb begin
      w_h_wrap   = (r_hcount == H_LAST);
      w_v_wrap   = (r_vcount == V_LAST);
      w_line_adv = r_pix_en && w_h_wrap;
      w_h_next   = r_hcount;
      w_v_next   = r_vcount;
      if (r_pix_en) begin
         if (w_h_wrap) begin
            w_h_next = coord_t'(0);
            w_v_next = w_v_wrap ? coord_t'(0) : r_vcount + coord_t'(1);
         end else begin
            w_h_next = r_hcount + coord_t'(1);
         end
      end else begin
         w_h_next = r_hcount;
      end
      w_bright_next = (w_h_next < coord_t'(H_VISIBLE)) && (w_v_next < coord_t'(V_VISIBLE));
      w_hit_next    = w_x_in && w_x_inside && w_y_in && w_y_inside && w_bright_next;
   end

   tile_axis_decoder #(
      .C0    (BOARD_X0),
      .PITCH (TILE_PITCH),
      .SIZE  (TILE_SIZE)
   ) u_x_axis (
      .clk          (Clk),
      .rst          (Reset),
      .i_coord_next (w_h_next),
      .i_advance    (r_pix_en),
      .i_wrap       (w_h_wrap),
      .o_in_board   (w_x_in),
      .o_index      (w_x_idx),
      .o_inside     (w_x_inside)
   );

   tile_axis_decoder #(
      .C0    (BOARD_Y0),
      .PITCH (TILE_PITCH),
      .SIZE  (TILE_SIZE)
   ) u_y_axis (
      .clk          (Clk),
      .rst          (Reset),
      .i_coord_next (w_v_next),
      .i_advance    (w_line_adv),
      .i_wrap       (w_v_wrap),
      .o_in_board   (w_y_in),
      .o_index      (w_y_idx),
      .o_inside     (w_y_inside)
   );

   // Registered raster outputs, all updated on the same edge so they never skew
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_hcount      <= H_LAST;
         r_vcount      <= V_LAST;
         r_bright      <= 1'b0;
         r_hsync       <= ~SYNC_ACTIVE;
         r_vsync       <= ~SYNC_ACTIVE;
         r_frame_start <= 1'b0;
         r_tile_hit    <= 1'b0;
         r_tile_row    <= tile_idx_t'(0);
         r_tile_col    <= tile_idx_t'(0);
      end else if (r_pix_en) begin
         r_hcount      <= w_h_next;
         r_vcount      <= w_v_next;
         r_bright      <= w_bright_next;
         r_hsync       <= sync_level(in_range(w_h_next, H_SYNC_START, H_SYNC_END));
         r_vsync       <= sync_level(in_range(w_v_next, V_SYNC_START, V_SYNC_END));
         r_frame_start <= (w_h_next == coord_t'(0)) && (w_v_next == coord_t'(0));
         r_tile_hit    <= w_hit_next;
         if (w_hit_next) begin
            r_tile_row <= w_y_idx;
            r_tile_col <= w_x_idx;
         end else begin
            r_tile_row <= r_tile_row;
            r_tile_col <= r_tile_col;
         end
      end else begin
         r_frame_start <= 1'b0;
      end
   end

   assign vif.pix_en      = r_pix_en;
   assign vif.hCount      = r_hcount;
   assign vif.vCount      = r_vcount;
   assign vif.bright      = r_bright;
   assign vif.hSync       = r_hsync;
   assign vif.vSync       = r_vsync;
   assign vif.frame_start = r_frame_start;
   assign vif.tile_hit    = r_tile_hit;
   assign vif.tile_row    = r_tile_row;
   assign vif.tile_col    = r_tile_col;

endmodule
